// File: rtl/vram_scan.sv
// VRAM frame-buffer scan-out: walks a 64-row x 256-nibble buffer onto a VGA-style raster,
// repeating each row LINE_REP times inside a vertically centred window.
module vram_scan #(
    parameter int H_ACTIVE = 640,   // multiple of 4: four pixels per nibble
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int LINE_REP = 4,
    parameter int V_OFS    = 112,
    parameter bit SYNC_POL = 1'b0,
    parameter bit BORDER   = 1'b0
) (
    input  logic        mck,
    input  logic        rin,
    input  logic        pix_ce,
    input  logic        lcdon,
    output logic [13:0] vram_a,
    input  logic [3:0]  vram_di,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        pix,
    output logic        sof
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);
    localparam int RW      = (LINE_REP > 1) ? $clog2(LINE_REP) : 1;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] WIN_BEG  = VW'(V_OFS);
    localparam logic [VW-1:0] WIN_END  = VW'(V_OFS + 64 * LINE_REP);
    localparam logic [RW-1:0] REP_LAST = RW'(LINE_REP - 1);

    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;
    logic [5:0]    row_q, row_d;
    logic [RW-1:0] rep_q, rep_d;
    logic [3:0]    shift_q, shift_d;
    logic [13:0]   addr_q, addr_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          de_q, de_d;
    logic          pix_q, pix_d;
    logic          sof_q, sof_d;

    logic          h_wrap, v_wrap, in_win, active, px_bit;
    logic [5:0]    row_nl;
    logic [RW-1:0] rep_nl;

    assign h_wrap = (hcnt_q == H_LAST);
    assign v_wrap = (vcnt_q == V_LAST);
    assign in_win = (vcnt_q >= WIN_BEG) && (vcnt_q < WIN_END);
    assign active = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
    // Phase 0 shows the nibble straight off the read port, the same tick it is captured.
    assign px_bit = (hcnt_q[1:0] == 2'd0) ? vram_di[3] : shift_q[~hcnt_q[1:0]];

    // Row/rep the next raster line will use; shared by the line wrap and the address preload.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
        row_nl = row_q;
        rep_nl = rep_q;
        if (v_wrap) begin
            row_nl = '0;
            rep_nl = '0;
        end else if (in_win) begin
            if (rep_q == REP_LAST) begin
                rep_nl = '0;
                if (row_q != 6'd63) row_nl = row_q + 6'd1;
            end else begin
                rep_nl = rep_q + 1'b1;
            end
        end
    end

    always_comb begin
        hcnt_d  = hcnt_q;
        vcnt_d  = vcnt_q;
        row_d   = row_q;
        rep_d   = rep_q;
        shift_d = shift_q;
        addr_d  = addr_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        de_d    = de_q;
        pix_d   = pix_q;
        sof_d   = sof_q;
        if (pix_ce) begin
            hcnt_d = h_wrap ? '0 : hcnt_q + 1'b1;
            if (h_wrap) begin
                vcnt_d = v_wrap ? '0 : vcnt_q + 1'b1;
                row_d  = row_nl;
                rep_d  = rep_nl;
            end
            de_d    = active;
            hsync_d = (hcnt_q >= HS_BEG && hcnt_q < HS_END) ? SYNC_POL : ~SYNC_POL;
            vsync_d = (vcnt_q >= VS_BEG && vcnt_q < VS_END) ? SYNC_POL : ~SYNC_POL;
            sof_d   = (hcnt_q == '0) && (vcnt_q == '0);
            pix_d   = active && lcdon && (in_win ? px_bit : BORDER);
            if (active && hcnt_q[1:0] == 2'd0) begin
                shift_d     = vram_di;
                addr_d[7:0] = addr_q[7:0] + 8'd1;
            end
            // Preload in the blanking gap so the first address is settled long before use.
            if (hcnt_q == H_ACT) addr_d = {row_nl, 8'd0};
        end
    end

    always_ff @(posedge mck) begin
        // NOTE: non-blocking assignments here so every flop samples pre-edge values.
        if (rin) begin
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            row_q   <= '0;
            rep_q   <= '0;
            shift_q <= '0;
            addr_q  <= '0;
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
            de_q    <= 1'b0;
            pix_q   <= 1'b0;
            sof_q   <= 1'b0;
        end else begin
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            row_q   <= row_d;
            rep_q   <= rep_d;
            shift_q <= shift_d;
            addr_q  <= addr_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            pix_q   <= pix_d;
            sof_q   <= sof_d;
        end
    end

    assign vram_a = addr_q;
    assign hsync  = hsync_q;
    assign vsync  = vsync_q;
    assign de     = de_q;
    assign pix    = pix_q;
    assign sof    = sof_q;

endmodule

// File: tb/tb_vram_scan.sv
// Directed bench for vram_scan: a shrunken raster (24x142, window lines 4..131, 2 lines/row,
// BORDER=1) for frame-level checks, plus a default-sized instance for the 800-tick line.
module tb_vram_scan;

    localparam int HT = 24, VT = 142, FRAME = HT * VT;

    logic        mck = 1'b0, rin = 1'b1, pix_ce = 1'b0, lcdon = 1'b1;
    logic [13:0] vram_a, f_vram_a;
    logic [3:0]  vram_di, f_vram_di;
    logic        hsync, vsync, de, pix, sof;
    logic        f_hsync, f_vsync, f_de, f_pix, f_sof;

    int checks = 0, fails = 0;
    int h = 0, v = 0, cur_h = 0, cur_v = 0, ce_div = 1;

    // VRAM content: nibble n of row r = (r + n) & 4'hF, returned combinationally.
    assign vram_di   = vram_a[11:8] + vram_a[3:0];
    assign f_vram_di = f_vram_a[11:8] + f_vram_a[3:0];

    always #5 mck = ~mck;

    vram_scan #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(136), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .LINE_REP(2), .V_OFS(4), .SYNC_POL(1'b0), .BORDER(1'b1)
    ) u_dut (
        .mck(mck), .rin(rin), .pix_ce(pix_ce), .lcdon(lcdon),
        .vram_a(vram_a), .vram_di(vram_di),
        .hsync(hsync), .vsync(vsync), .de(de), .pix(pix), .sof(sof)
    );

    vram_scan u_full (
        .mck(mck), .rin(rin), .pix_ce(pix_ce), .lcdon(lcdon),
        .vram_a(f_vram_a), .vram_di(f_vram_di),
        .hsync(f_hsync), .vsync(f_vsync), .de(f_de), .pix(f_pix), .sof(f_sof)
    );

    task automatic adv();
        cur_h = h;
        cur_v = v;
        if (h == HT - 1) begin
            h = 0;
            v = (v == VT - 1) ? 0 : v + 1;
        end else begin
            h = h + 1;
        end
    endtask

    // One pixel tick; in 1-in-3 mode two idle mck edges precede it. Samples 1 time unit after the edge.
    task automatic step();
        if (ce_div == 3) begin
            pix_ce = 1'b0;
            @(posedge mck); #1;
            @(posedge mck); #1;
        end
        pix_ce = 1'b1;
        @(posedge mck); #1;
        adv();
    endtask

    task automatic goto(input int tv, input int th);
        int budget;
        budget = 2 * FRAME;
        while (!(v == tv && h == th) && budget > 0) begin
            step();
            budget--;
        end
        if (budget == 0) begin
            checks++; fails++;
            $display("FAIL goto(%0d,%0d): position never reached", tv, th);
        end
    endtask

    task automatic test_reset();
        rin = 1'b1; pix_ce = 1'b1; lcdon = 1'b1;
        repeat (3) @(posedge mck);
        #1;
        checks++;
        if (vram_a !== 14'h0) begin fails++; $display("FAIL reset_vram_a: got %h want 0000", vram_a); end
        checks++;
        if ({de, pix, sof} !== 3'b000) begin fails++; $display("FAIL reset_de_pix_sof: got %b want 000", {de, pix, sof}); end
        checks++;
        if ({hsync, vsync} !== 2'b11) begin fails++; $display("FAIL reset_syncs: got %b want 11", {hsync, vsync}); end
        checks++;
        if ({f_vram_a, f_de, f_pix, f_sof, f_hsync, f_vsync} !== {14'h0, 5'b00011}) begin
            fails++; $display("FAIL reset_full: got %h %b want 0000 00011", f_vram_a, {f_de, f_pix, f_sof, f_hsync, f_vsync});
        end
        rin = 1'b0;
        h = 0; v = 0;
    endtask

    task automatic test_timing();
        int hs_f[3], vs_f[2], sof_t[2];
        int nhs = 0, nvs = 0, nsof = 0, hs_low = 0, vs_low = 0, de_fall = -1, pix_no_de = 0;
        int fhs_f[2];
        int nfhs = 0, fhs_low = 0, fde_hi = 0;
        logic p_hs, p_vs, p_de, p_fhs;
        p_hs = hsync; p_vs = vsync; p_de = de; p_fhs = f_hsync;
        for (int n = 0; n < 2 * FRAME; n++) begin
            step();
            if (p_hs && !hsync && nhs < 3) begin hs_f[nhs] = n; nhs++; end
            if (p_vs && !vsync && nvs < 2) begin vs_f[nvs] = n; nvs++; end
            if (sof) begin if (nsof < 2) sof_t[nsof] = n; nsof++; end
            if (n < HT && !hsync) hs_low++;
            if (n < FRAME && !vsync) vs_low++;
            if (p_de && !de && de_fall < 0) de_fall = n;
            if (pix && !de) pix_no_de++;
            if (p_fhs && !f_hsync && nfhs < 2) begin fhs_f[nfhs] = n; nfhs++; end
            if (n < 800 && !f_hsync) fhs_low++;
            if (n < 800 && f_de) fde_hi++;
            p_hs = hsync; p_vs = vsync; p_de = de; p_fhs = f_hsync;
        end
        checks++;
        if (nhs < 3 || hs_f[0] != 18 || hs_f[2] - hs_f[1] != 24) begin
            fails++; $display("FAIL hsync_period: falls %0d first %0d period %0d want first 18 period 24", nhs, hs_f[0], hs_f[2] - hs_f[1]);
        end
        checks++;
        if (hs_low != 4) begin fails++; $display("FAIL hsync_low: got %0d want 4", hs_low); end
        checks++;
        if (nvs < 2 || vs_f[0] != 3312 || vs_f[1] - vs_f[0] != FRAME) begin
            fails++; $display("FAIL vsync_period: first %0d period %0d want 3312 %0d", vs_f[0], vs_f[1] - vs_f[0], FRAME);
        end
        checks++;
        if (vs_low != 48) begin fails++; $display("FAIL vsync_low: got %0d want 48", vs_low); end
        checks++;
        if (nsof != 2 || sof_t[0] != 0 || sof_t[1] != FRAME) begin
            fails++; $display("FAIL sof_pulse: count %0d at %0d,%0d want 2 at 0,%0d", nsof, sof_t[0], sof_t[1], FRAME);
        end
        checks++;
        if (de_fall != 16) begin fails++; $display("FAIL de_width: falls at %0d want 16", de_fall); end
        checks++;
        if (pix_no_de != 0) begin fails++; $display("FAIL pix_outside_de: got %0d ticks want 0", pix_no_de); end
        checks++;
        if (nfhs < 2 || fhs_f[0] != 656 || fhs_f[1] - fhs_f[0] != 800) begin
            fails++; $display("FAIL full_hsync_period: first %0d period %0d want 656 800", fhs_f[0], fhs_f[1] - fhs_f[0]);
        end
        checks++;
        if (fhs_low != 96 || fde_hi != 640) begin
            fails++; $display("FAIL full_hsync_low_de: low %0d de %0d want 96 640", fhs_low, fde_hi);
        end
    endtask

    task automatic test_border();
        int lines[2];
        lines = '{3, 132};
        foreach (lines[k]) begin
            goto(lines[k], 0);
            for (int i = 0; i < HT; i++) begin
                step();
                checks++;
                if (pix !== (i < 16) || de !== (i < 16)) begin
                    fails++; $display("FAIL border v%0d h%0d: pix %b de %b want %b", lines[k], i, pix, de, (i < 16));
                end
            end
        end
    endtask

    task automatic test_pixels();
        logic [7:0]  p4;
        logic [11:0] p6;
        logic [15:0] p131;
        p4 = 8'b0000_0001; p6 = 12'b0001_0010_0011; p131 = 16'b1111_0000_0001_0010;
        goto(4, 0);
        for (int i = 0; i < 8; i++) begin
            step(); checks++;
            if (pix !== p4[7-i]) begin fails++; $display("FAIL pix v4 h%0d: got %b want %b", i, pix, p4[7-i]); end
        end
        goto(6, 0);
        for (int i = 0; i < 12; i++) begin
            step(); checks++;
            if (pix !== p6[11-i]) begin fails++; $display("FAIL pix v6 h%0d: got %b want %b", i, pix, p6[11-i]); end
        end
        goto(131, 0);
        for (int i = 0; i < 16; i++) begin
            step(); checks++;
            if (pix !== p131[15-i]) begin fails++; $display("FAIL pix v131 h%0d: got %b want %b", i, pix, p131[15-i]); end
        end
    endtask

    task automatic test_address();
        logic [13:0] e5[5];
        e5 = '{14'h001, 14'h002, 14'h003, 14'h004, 14'h100};
        goto(5, 0);
        for (int i = 0; i <= 16; i++) begin
            step();
            if (i % 4 == 0) begin
                checks++;
                if (vram_a !== e5[i/4]) begin fails++; $display("FAIL addr v5 h%0d: got %h want %h", i, vram_a, e5[i/4]); end
            end
        end
        goto(129, 0); step(); checks++;
        if (vram_a !== 14'h3E01) begin fails++; $display("FAIL addr v129 h0: got %h want 3e01", vram_a); end
        goto(129, 16); step(); checks++;
        if (vram_a !== 14'h3F00) begin fails++; $display("FAIL addr v129 h16: got %h want 3f00", vram_a); end
        goto(131, 4); step(); checks++;
        if (vram_a !== 14'h3F02) begin fails++; $display("FAIL addr v131 h4: got %h want 3f02", vram_a); end
        goto(131, 16); step(); checks++;
        if (vram_a !== 14'h3F00) begin fails++; $display("FAIL addr v131 h16: got %h want 3f00", vram_a); end
        goto(133, 4); step(); checks++;
        if (vram_a !== 14'h3F02) begin fails++; $display("FAIL addr v133 h4: got %h want 3f02", vram_a); end
        goto(141, 15); step(); checks++;
        if (vram_a !== 14'h3F00) begin fails++; $display("FAIL addr v141 h15: got %h want 3f00", vram_a); end
        step(); checks++;
        if (vram_a !== 14'h0000) begin fails++; $display("FAIL addr v141 h16: got %h want 0000", vram_a); end
    endtask

    task automatic test_lcdon();
        lcdon = 1'b1;
        goto(32, 4);
        step(); checks++;
        if (pix !== 1'b1) begin fails++; $display("FAIL lcdon_on v32 h4: got %b want 1", pix); end
        step(); checks++;
        if (pix !== 1'b1) begin fails++; $display("FAIL lcdon_on v32 h5: got %b want 1", pix); end
        lcdon = 1'b0;
        step(); checks++;
        if ({pix, de, hsync, vsync} !== 4'b0111) begin
            fails++; $display("FAIL lcdon_off v32 h6: pix/de/hs/vs %b want 0111", {pix, de, hsync, vsync});
        end
        for (int i = 7; i < HT; i++) begin
            step(); checks++;
            if (pix !== 1'b0 || de !== (i < 16) || hsync !== !(i >= 18 && i < 22)) begin
                fails++; $display("FAIL lcdon_off v32 h%0d: pix %b de %b hs %b", i, pix, de, hsync);
            end
        end
        lcdon = 1'b1;
        goto(33, 4);
        step(); checks++;
        if (pix !== 1'b1) begin fails++; $display("FAIL lcdon_back v33 h4: got %b want 1", pix); end
    endtask

    task automatic test_reset_midframe();
        int hs_f[2];
        int nhs = 0, hs_low = 0, sof_hi = 0;
        logic p_hs;
        ce_div = 3;
        goto(70, 10);
        rin = 1'b1; pix_ce = 1'b1;
        for (int e = 0; e < 3; e++) begin
            @(posedge mck); #1;
            pix_ce = 1'b0;
            checks++;
            if ({vram_a, de, pix, sof, hsync, vsync} !== {14'h0, 5'b00011}) begin
                fails++; $display("FAIL midreset_hold e%0d: got %h %b want 0000 00011", e, vram_a, {de, pix, sof, hsync, vsync});
            end
        end
        rin = 1'b0;
        h = 0; v = 0;
        p_hs = hsync;
        for (int e = 1; e <= 150; e++) begin
            pix_ce = (e % 3 == 0);
            @(posedge mck); #1;
            if (pix_ce) adv();
            if (e == 3) begin
                checks++;
                if ({sof, de} !== 2'b11) begin fails++; $display("FAIL midreset_first_tick: sof/de %b want 11", {sof, de}); end
            end
            if (p_hs && !hsync && nhs < 2) begin hs_f[nhs] = e; nhs++; end
            if (e <= 72 && !hsync) hs_low++;
            if (e <= 72 && sof) sof_hi++;
            p_hs = hsync;
        end
        checks++;
        if (nhs < 2 || hs_f[0] != 57 || hs_f[1] - hs_f[0] != 72) begin
            fails++; $display("FAIL midreset_hsync: first %0d period %0d want 57 72", hs_f[0], hs_f[1] - hs_f[0]);
        end
        checks++;
        if (hs_low != 12 || sof_hi != 3) begin
            fails++; $display("FAIL midreset_widths: hs_low %0d sof %0d want 12 3", hs_low, sof_hi);
        end
        ce_div = 1;
    endtask

    initial begin
        test_reset();
        test_timing();
        test_border();
        test_pixels();
        test_address();
        test_lcdon();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
